bcd_key_counter: RTL and testbench
==================================

Name: bcd_key_counter

Overview:
- Parametrised successor of the two-digit key-press counter.
- Counts debounced presses of separate up and down keys as a DIGITS-wide BCD value, wraps at MAX_VALUE, and drives one 9-bit seven-segment pattern per digit.
- The BCD digit chain removes the /10 and %10 arithmetic.
- Sits between the raw board keys and the segment display pins.

Parameters:
- DIGITS, 2: number of BCD digits / segment outputs (1..4).
- MAX_VALUE, 99: highest count value; must be ≤ 10^DIGITS-1.
- DB_CYCLES, 240000: clk cycles a key must be stably pressed before it registers (20 ms at 12 MHz).
- REPEAT_DELAY, 6000000: hold time before auto-repeat starts (optional feature only).
- REPEAT_PERIOD, 2400000: interval between auto-repeat steps (optional feature only).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-low
- key_up  input  1  raw up key, active-low (pressed = 0)
- key_down  input  1  raw down key, active-low
- clr  input  1  synchronous clear, active-high level
- count_bcd  output  4*DIGITS  current count in BCD; digit 0 (units) in [3:0]
- wrap  output  1  one-cycle pulse on wrap-around in either direction
- seg_led  output  9*DIGITS  segment pattern per digit; digit 0 in [8:0]

Behaviour:
- Reset (rst=0, async):
  - count_bcd=0, wrap=0, seg_led shows "0" on every digit (9'h03f per digit).
  - Debounce counters cleared; key state = released.
- Input synchronisation: each key passes through 2 flip-flops before debounce.
- Debounce, per key, with independent counters:
  - Count consecutive cycles the synchronised key is 0. Any 1 resets the counter.
  - When the count reaches DB_CYCLES, emit a one-cycle internal press pulse and latch "held".
  - Release also needs DB_CYCLES stable 1 cycles before a new press can be accepted.
  - One physical press produces exactly one pulse.
- Count update, on the clk edge after the pulse, priority highest first:
  - clr=1: count=0, wrap=0. Pending pulses that cycle are discarded.
  - up and down pulses in the same cycle: no change.
  - up pulse, count<MAX_VALUE: count+1 with BCD digit carry (9 -> 0, carry to the next digit).
  - up pulse, count==MAX_VALUE: count=0, wrap=1 for one cycle.
  - down pulse, count>0: count-1 with BCD borrow (0 -> 9, borrow from the next digit).
  - down pulse, count==0: count=MAX_VALUE, wrap=1 for one cycle.
- Each BCD digit always holds 0..9. Count never exceeds MAX_VALUE.
- Latency:
  - count_bcd changes 1 clk after the internal pulse.
  - seg_led is registered and follows count_bcd 1 clk later.
  - Total from the DB_CYCLES-th stable sample to the display: 2 clk.
- Segment encoding:
  - Bits [6:0] = gfedcba, active-high. Bits [8:7] = 0.
  - Digit patterns 0..9: 3f 06 5b 4f 66 6d 7d 07 7f 6f.
- Reset mid-debounce or mid-hold: all state cleared. A key still held after reset release must satisfy DB_CYCLES again before it counts.

Optional Feature:
- Macro: BCD_KEY_COUNTER_AUTOREPEAT_EN
- Defined: after a key has been held (debounced) for REPEAT_DELAY cycles, emit an extra pulse every REPEAT_PERIOD cycles until release. Wrap rules apply to every pulse. If both keys are held, no repeat pulses are emitted.
- Undefined: exactly one pulse per press. The repeat counters and the REPEAT_* parameters are unused and synthesise away.

Test Plan (DB_CYCLES=4, DIGITS=2, MAX_VALUE=99 unless stated):
- Reset release -> count_bcd=8'h00, wrap=0, seg_led={9'h03f,9'h03f}. Hold key_up=0 for 4+2 sync cycles -> count_bcd=8'h01 after 1 clk, seg_led[8:0]=9'h006 after 1 more clk.
- Bounce key_up 0/1 every 2 clk for 20 clk, then hold 0 for 10 clk -> exactly one increment.
- Preload to 8'h09 via 9 presses, press up -> count_bcd=8'h10. Reach 99, press up -> 8'h00 with a single-cycle wrap=1.
- From 0, press down -> 8'h99, wrap=1. Repeat with MAX_VALUE=59 -> 8'h59. Press down from 8'h10 -> 8'h09.
- Both key pulses in the same cycle -> no change. clr=1 asserted in the same cycle as an up pulse -> count=0, no wrap.
- With the macro defined (REPEAT_DELAY=20, REPEAT_PERIOD=8), hold key_up 60 clk -> 1 + 5 increments. Assert rst=0 mid-hold -> count 0, and no increment until DB_CYCLES elapse again.

Source files
------------

// File: rtl/bcd_key_counter.sv
// bcd_key_counter: debounced up/down key counter with a BCD digit chain and 7-segment drive.
// Define BCD_KEY_COUNTER_AUTOREPEAT_EN to enable hold-to-repeat on both keys.
module bcd_key_counter #(
  parameter int DIGITS        = 2,
  parameter int MAX_VALUE     = 99,
  parameter int DB_CYCLES     = 240000,
  parameter int REPEAT_DELAY  = 6000000,
  parameter int REPEAT_PERIOD = 2400000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_up,
  input  logic                  key_down,
  input  logic                  clr,
  output logic [4*DIGITS-1:0]   count_bcd,
  output logic                  wrap,
  output logic [9*DIGITS-1:0]   seg_led
);
  localparam int W  = 4*DIGITS;
  localparam int CW = $clog2(DB_CYCLES+1);
  localparam logic [69:0] SEG = {7'h6f, 7'h7f, 7'h07, 7'h7d, 7'h6d, 7'h66, 7'h4f, 7'h5b, 7'h06, 7'h3f};
  function automatic logic [W-1:0] to_bcd(input int v);
    int x;
    x = v;
    to_bcd = '0;
    for (int i = 0; i < DIGITS; i++) begin
      to_bcd[4*i+:4] = 4'(x % 10);
      x = x / 10;
    end
  endfunction
  localparam logic [W-1:0] MAX_BCD = to_bcd(MAX_VALUE);
  function automatic logic [W-1:0] step(input logic [W-1:0] v, input logic dn);
    logic c;
    logic [3:0] d;
    c = 1'b1;
    step = v;
    for (int i = 0; i < DIGITS; i++) begin
      d = v[4*i+:4];
      if (c) begin
        step[4*i+:4] = dn ? (d == 4'd0 ? 4'd9 : d - 4'd1) : (d == 4'd9 ? 4'd0 : d + 4'd1);
        c = dn ? d == 4'd0 : d == 4'd9;
      end
    end
  endfunction
  // index 0 = up key, index 1 = down key; keys are active-low
  logic [1:0] s1, s2, held, done, p, rep_p, up_dn;
  logic [CW-1:0] dcnt [2];
  always_comb
    for (int i = 0; i < 2; i++)
      done[i] = (s2[i] == held[i]) && (dcnt[i] == CW'(DB_CYCLES-1));
  assign p = done & ~held;
  // the same counter times a stable press (held=0) or a stable release (held=1)
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      s1   <= '1;
      s2   <= '1;
      held <= '0;
      dcnt <= '{default: '0};
    end else begin
      s1 <= {key_down, key_up};
      s2 <= s1;
      for (int i = 0; i < 2; i++) begin
        dcnt[i] <= (s2[i] != held[i] || done[i]) ? '0 : dcnt[i] + CW'(1);
        if (done[i]) held[i] <= ~held[i];
      end
    end
`ifdef BCD_KEY_COUNTER_AUTOREPEAT_EN
  localparam int RW = $clog2((REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD) + 1);
  logic [RW-1:0] rcnt [2];
  logic [1:0] first, hit;
  always_comb
    for (int i = 0; i < 2; i++)
      hit[i] = held[i] && !s2[i] && rcnt[i] == (first[i] ? RW'(REPEAT_DELAY-1) : RW'(REPEAT_PERIOD-1));
  assign rep_p = hit & {2{~&held}};
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rcnt  <= '{default: '0};
      first <= '1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        rcnt[i]  <= (!held[i] || s2[i] || hit[i]) ? '0 : rcnt[i] + RW'(1);
        first[i] <= (!held[i] || s2[i]) ? 1'b1 : (hit[i] ? 1'b0 : first[i]);
      end
    end
`else
  assign rep_p = 2'(0 * (REPEAT_DELAY + REPEAT_PERIOD));
`endif
  assign up_dn = p | rep_p;
  logic [W-1:0] cnt_n;
  logic wrap_n;
  logic [9*DIGITS-1:0] seg_n;
  always_comb begin
    cnt_n  = count_bcd;
    wrap_n = 1'b0;
    if (clr) cnt_n = '0;
    else if (up_dn == 2'b01) begin
      cnt_n  = count_bcd == MAX_BCD ? '0 : step(count_bcd, 1'b0);
      wrap_n = count_bcd == MAX_BCD;
    end else if (up_dn == 2'b10) begin
      cnt_n  = count_bcd == '0 ? MAX_BCD : step(count_bcd, 1'b1);
      wrap_n = count_bcd == '0;
    end
    for (int i = 0; i < DIGITS; i++)
      seg_n[9*i+:9] = {2'b00, SEG[7*count_bcd[4*i+:4] +: 7]};
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      count_bcd <= '0;
      wrap      <= 1'b0;
      seg_led   <= {DIGITS{9'h03f}};
    end else begin
      count_bcd <= cnt_n;
      wrap      <= wrap_n;
      seg_led   <= seg_n;
    end
endmodule

// File: tb/tb_bcd_key_counter.sv
// tb_bcd_key_counter: directed scoreboard bench for bcd_key_counter (DB_CYCLES=4, two digits).
module tb_bcd_key_counter;
  logic clk = 0, rst = 0, key_up = 1, key_down = 1, clr = 0, key_dn59 = 1;
  logic [7:0] count_bcd, count59, prev;
  logic wrap, wrap59, w59, rst_q = 0;
  logic [17:0] seg_led, seg59;
  logic [8:0] q[$];
  logic [8:0] e;
  int total = 0, bad = 0, m = 0;

  bcd_key_counter #(.DIGITS(2), .MAX_VALUE(99), .DB_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)) dut (
    .clk(clk), .rst(rst), .key_up(key_up), .key_down(key_down), .clr(clr),
    .count_bcd(count_bcd), .wrap(wrap), .seg_led(seg_led));
  bcd_key_counter #(.DIGITS(2), .MAX_VALUE(59), .DB_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)) dut59 (
    .clk(clk), .rst(rst), .key_up(1'b1), .key_down(key_dn59), .clr(clr),
    .count_bcd(count59), .wrap(wrap59), .seg_led(seg59));

  always #5 clk = ~clk;

  function automatic logic [8:0] enc(input logic [3:0] d);
    case (d)
      4'd0: enc = 9'h03f; 4'd1: enc = 9'h006; 4'd2: enc = 9'h05b; 4'd3: enc = 9'h04f;
      4'd4: enc = 9'h066; 4'd5: enc = 9'h06d; 4'd6: enc = 9'h07d; 4'd7: enc = 9'h007;
      4'd8: enc = 9'h07f; 4'd9: enc = 9'h06f; default: enc = 9'h1ff;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin bad++; $error("FAIL %s got=%0h exp=%0h", tag, got, exp); end
  endtask

  task automatic expect_step(input int dir);
    logic w;
    w = 1'b0;
    if (dir == 0) m = 0;
    else if (dir > 0) begin w = (m == 99); m = w ? 0 : m + 1; end
    else begin w = (m == 0); m = w ? 99 : m - 1; end
    q.push_back({w, 4'(m / 10), 4'(m % 10)});
  endtask

  task automatic press(input int k);
    expect_step(k == 0 ? 1 : -1);
    @(posedge clk); #1;
    if (k == 0) key_up = 0; else key_down = 0;
    repeat (8) @(posedge clk);
    #1 key_up = 1; key_down = 1;
    repeat (8) @(posedge clk);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge clk);
    chk(tag, q.size(), 0);
  endtask

  task automatic do_clr();
    expect_step(0);
    @(posedge clk); #1 clr = 1;
    @(posedge clk); #1 clr = 0;
  endtask

  // scoreboard: every count change must match the next queued result; seg follows count by one clk
  always @(negedge clk) begin
    if (rst && rst_q) begin
      total++;
      assert (seg_led === {enc(prev[7:4]), enc(prev[3:0])})
        else begin bad++; $error("FAIL seg got=%h exp_for=%h", seg_led, prev); end
      if (count_bcd !== prev) begin
        total++;
        assert (q.size() != 0) else begin bad++; $error("FAIL unexpected_change got=%h prev=%h", count_bcd, prev); end
        if (q.size() != 0) begin
          e = q.pop_front();
          total++;
          assert ({wrap, count_bcd} === e) else begin bad++; $error("FAIL step got=%h exp=%h", {wrap, count_bcd}, e); end
        end
      end else begin
        total++;
        assert (wrap === 1'b0) else begin bad++; $error("FAIL wrap_idle got=%b exp=0", wrap); end
      end
    end
    prev = count_bcd;
    rst_q = rst;
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1;
    chk("rst_count", count_bcd, 8'h00);
    chk("rst_wrap", wrap, 0);
    chk("rst_seg", seg_led, {9'h03f, 9'h03f});
    expect_step(1);
    @(posedge clk); #1 key_up = 0;
    repeat (5) @(posedge clk);
    #1 chk("lat_pre", count_bcd, 8'h00);
    @(posedge clk); #1;
    chk("lat_cnt", count_bcd, 8'h01);
    chk("lat_seg_pre", seg_led[8:0], 9'h03f);
    @(posedge clk); #1;
    chk("lat_seg", seg_led[8:0], 9'h006);
    key_up = 1;
    repeat (8) @(posedge clk);
    drain("lat_drain");
    expect_step(1);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      key_up = 0; repeat (2) @(posedge clk); #1;
      key_up = 1; repeat (2) @(posedge clk); #1;
    end
    key_up = 0;
    repeat (10) @(posedge clk);
    #1 key_up = 1;
    repeat (8) @(posedge clk);
    drain("bounce_drain");
    chk("bounce_cnt", count_bcd, 8'h02);
    do_clr();
    for (int i = 0; i < 9; i++) press(0);
    drain("pre9_drain");
    chk("pre9_cnt", count_bcd, 8'h09);
    press(0);
    drain("carry_drain");
    chk("carry_cnt", count_bcd, 8'h10);
    for (int i = 0; i < 89; i++) press(0);
    drain("to99_drain");
    chk("to99_cnt", count_bcd, 8'h99);
    press(0);
    drain("wrap_up_drain");
    chk("wrap_up_cnt", count_bcd, 8'h00);
    press(1);
    drain("wrap_dn_drain");
    chk("wrap_dn_cnt", count_bcd, 8'h99);
    @(posedge clk); #1 key_dn59 = 0;
    for (int i = 0; i < 20 && count59 === 8'h00; i++) begin @(posedge clk); #1; end
    w59 = wrap59;
    chk("max59_cnt", count59, 8'h59);
    chk("max59_wrap", w59, 1);
    repeat (4) @(posedge clk);
    #1 key_dn59 = 1;
    repeat (8) @(posedge clk);
    do_clr();
    for (int i = 0; i < 10; i++) press(0);
    press(1);
    drain("borrow_drain");
    chk("borrow_cnt", count_bcd, 8'h09);
    @(posedge clk); #1 key_up = 0; key_down = 0;
    repeat (8) @(posedge clk);
    #1 key_up = 1; key_down = 1;
    repeat (8) @(posedge clk);
    drain("both_drain");
    chk("both_cnt", count_bcd, 8'h09);
    expect_step(0);
    @(posedge clk); #1 key_up = 0;
    repeat (5) @(posedge clk);
    #1 clr = 1;
    @(posedge clk); #1 clr = 0;
    repeat (3) @(posedge clk);
    #1 key_up = 1;
    repeat (8) @(posedge clk);
    drain("clr_up_drain");
    chk("clr_up_cnt", count_bcd, 8'h00);
    expect_step(1);
    @(posedge clk); #1 key_up = 0;
    repeat (10) @(posedge clk);
    #1 rst = 0;
    m = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    chk("rst_mid_cnt", count_bcd, 8'h00);
    chk("rst_mid_q", q.size(), 0);
    expect_step(1);
    repeat (5) @(posedge clk);
    #1 chk("rst_redb_pre", count_bcd, 8'h00);
    drain("rst_redb_drain");
    key_up = 1;
    repeat (8) @(posedge clk);
    chk("rst_redb_cnt", count_bcd, 8'h01);
`ifdef BCD_KEY_COUNTER_AUTOREPEAT_EN
    for (int i = 0; i < 6; i++) expect_step(1);
    @(posedge clk); #1 key_up = 0;
    repeat (60) @(posedge clk);
    #1 key_up = 1;
    repeat (8) @(posedge clk);
    drain("rep_drain");
    chk("rep_cnt", count_bcd, 8'h07);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
